// File: rtl/mem_responder_if.sv
// CPU memory bus, program-loader stream and I/O port seen by mem_responder.
// The processor/board side uses master; the responder uses slave.
interface mem_responder_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    // CPU memory bus
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;
    logic              write;
    logic              cpu_reset;

    // byte-stream program loader
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_ready;
    logic              reload;
    logic              loaded;

    // memory-mapped I/O port
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_out;
    logic              io_strobe;

    modport master (
        output mem_addr, mem_in, write, ld_data, ld_valid, reload, io_in,
        input  mem_out, cpu_reset, ld_ready, loaded, io_out, io_strobe
    );

    modport slave (
        input  mem_addr, mem_in, write, ld_data, ld_valid, reload, io_in,
        output mem_out, cpu_reset, ld_ready, loaded, io_out, io_strobe
    );
endinterface

// File: rtl/mem_responder.sv
// 256x8 RAM responder for the 8-bit CPU with a header-driven program loader
// that holds the CPU in reset until the image is in memory, plus one I/O port.
module mem_responder #(
    parameter logic [7:0] IO_ADDR = 8'hFF,
    parameter bit         IO_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        HDR_ADDR = 2'd0,
        HDR_LEN  = 2'd1,
        DATA     = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] cnt;
    logic [DATA_W-1:0] ram [DEPTH];

    logic              io_hit;
    logic              ld_ready_c;
    logic              ld_xfer;
    logic              io_wr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    logic              cpu_reset_q;
    logic              loaded_q;
    logic [DATA_W-1:0] io_out_q;
    logic              io_strobe_q;

    assign io_hit = IO_EN && (bus.mem_addr == IO_ADDR);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR_ADDR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; reload overrides any pending transfer
    always_comb begin
        next_state = state;
        if (bus.reload) begin
            next_state = HDR_ADDR;
        end else begin
            case (state)
                HDR_ADDR: if (bus.ld_valid) next_state = HDR_LEN;
                HDR_LEN:  if (bus.ld_valid) next_state = DATA;
                DATA:     if (bus.ld_valid && cnt == DATA_W'(1)) next_state = RUN;
                RUN:      next_state = RUN;
                default:  next_state = HDR_ADDR;
            endcase
        end
    end

    // Output/control decode: handshake and a single RAM write port shared by
    // the loader (load states) and the CPU (RUN only)
    always_comb begin
        ld_ready_c = 1'b0;
        ld_xfer    = 1'b0;
        io_wr      = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = ptr;
        ram_wdata  = bus.ld_data;
        if (!bus.reload) begin
            case (state)
                HDR_ADDR, HDR_LEN: begin
                    ld_ready_c = 1'b1;
                    ld_xfer    = bus.ld_valid;
                end
                DATA: begin
                    ld_ready_c = 1'b1;
                    ld_xfer    = bus.ld_valid;
                    ram_we     = bus.ld_valid;
                end
                RUN: begin
                    if (bus.write) begin
                        if (io_hit) begin
                            io_wr = 1'b1;
                        end else begin
                            ram_we    = 1'b1;
                            ram_waddr = bus.mem_addr;
                            ram_wdata = bus.mem_in;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Load pointer and remaining byte count (0 encodes 256)
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (ld_xfer) begin
            case (state)
                HDR_ADDR: ptr <= bus.ld_data;
                HDR_LEN:  cnt <= bus.ld_data;
                DATA: begin
                    ptr <= ptr + ADDR_W'(1);
                    cnt <= cnt - DATA_W'(1);
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset so an image survives a board reset
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Registered status and I/O outputs; cpu_reset/loaded track the state
    // being entered so they change on the same edge as the FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_reset_q <= 1'b1;
            loaded_q    <= 1'b0;
            io_out_q    <= '0;
            io_strobe_q <= 1'b0;
        end else begin
            cpu_reset_q <= (next_state != RUN);
            loaded_q    <= (next_state == RUN);
            io_strobe_q <= io_wr;
            if (io_wr) begin
                io_out_q <= bus.mem_in;
            end
        end
    end

    assign bus.mem_out   = io_hit ? bus.io_in : ram[bus.mem_addr];
    assign bus.ld_ready  = ld_ready_c;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.loaded    = loaded_q;
    assign bus.io_out    = io_out_q;
    assign bus.io_strobe = io_strobe_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (I/O decode on and off)
// share stimulus; a behavioural model predicts every output each cycle.
module tb_mem_responder;
    localparam int K_MEMOUT = 0;
    localparam int K_CPURST = 1;
    localparam int K_LOADED = 2;
    localparam int K_LDRDY  = 3;
    localparam int K_IOOUT  = 4;
    localparam int K_IOSTB  = 5;
    localparam int K_XFER   = 6;

    typedef struct {
        int         d;
        int         k;
        logic [7:0] e;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] s_addr, s_din, s_ld_data, s_io_in;
    logic       s_write, s_ld_valid, s_reload;

    mem_responder_if if0();
    mem_responder_if if1();

    assign if0.mem_addr = s_addr;
    assign if0.mem_in   = s_din;
    assign if0.write    = s_write;
    assign if0.ld_data  = s_ld_data;
    assign if0.ld_valid = s_ld_valid;
    assign if0.reload   = s_reload;
    assign if0.io_in    = s_io_in;
    assign if1.mem_addr = s_addr;
    assign if1.mem_in   = s_din;
    assign if1.write    = s_write;
    assign if1.ld_data  = s_ld_data;
    assign if1.ld_valid = s_ld_valid;
    assign if1.reload   = s_reload;
    assign if1.io_in    = s_io_in;

    mem_responder #(.IO_ADDR(8'hFF), .IO_EN(1'b1)) u_io (
        .clk(clk), .reset(reset), .bus(if0.slave)
    );
    mem_responder #(.IO_ADDR(8'hFF), .IO_EN(1'b0)) u_noio (
        .clk(clk), .reset(reset), .bus(if1.slave)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_ram   [2][256];
    bit         m_known [2][256];
    logic [7:0] m_ldq[$];
    bit         m_run;
    logic [7:0] m_io_out [2];
    bit         m_strobe [2];

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    int   xfer_cnt = 0;
    bit   cnt_clr = 1'b0;

    always @(posedge clk) begin
        if (cnt_clr) xfer_cnt <= 0;
        else if (!reset && s_ld_valid && if0.ld_ready) xfer_cnt <= xfer_cnt + 1;
    end

    function automatic string kname(int k);
        case (k)
            K_MEMOUT: return "mem_out";
            K_CPURST: return "cpu_reset";
            K_LOADED: return "loaded";
            K_LDRDY:  return "ld_ready";
            K_IOOUT:  return "io_out";
            K_IOSTB:  return "io_strobe";
            default:  return "xfer_count";
        endcase
    endfunction

    function automatic logic [7:0] actual(int d, int k);
        case (k)
            K_MEMOUT: return (d == 0) ? if0.mem_out : if1.mem_out;
            K_CPURST: return 8'((d == 0) ? if0.cpu_reset : if1.cpu_reset);
            K_LOADED: return 8'((d == 0) ? if0.loaded : if1.loaded);
            K_LDRDY:  return 8'((d == 0) ? if0.ld_ready : if1.ld_ready);
            K_IOOUT:  return (d == 0) ? if0.io_out : if1.io_out;
            K_IOSTB:  return 8'((d == 0) ? if0.io_strobe : if1.io_strobe);
            default:  return 8'(xfer_cnt);
        endcase
    endfunction

    // Monitor: compare everything queued for this cycle away from the edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t       x;
            logic [7:0] a;
            x = exp_q.pop_front();
            a = actual(x.d, x.k);
            n_cmp++;
            if (a !== x.e) begin
                n_bad++;
                $display("FAIL %s dut%0d t=%0t: got %02h want %02h",
                         kname(x.k), x.d, $time, a, x.e);
            end
        end
    end

    task automatic check_now(string name, logic [7:0] got, logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %02h want %02h", name, $time, got, want);
        end
    endtask

    task automatic push(int d, int k, logic [7:0] e);
        exp_t x;
        x.d = d; x.k = k; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic push_expect();
        if (!chk_en) return;
        for (int d = 0; d < 2; d++) begin
            push(d, K_CPURST, 8'(!m_run));
            push(d, K_LOADED, 8'(m_run));
            push(d, K_LDRDY,  8'(!m_run && !s_reload));
            push(d, K_IOOUT,  m_io_out[d]);
            push(d, K_IOSTB,  8'(m_strobe[d]));
            if (d == 0 && s_addr == 8'hFF) push(d, K_MEMOUT, s_io_in);
            else if (m_known[d][s_addr]) push(d, K_MEMOUT, m_ram[d][s_addr]);
        end
    endtask

    // Effect of one clock edge given the inputs held across it
    task automatic model_edge();
        int n;
        int len;
        if (reset) begin
            m_ldq.delete();
            m_run = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_io_out[d] = 8'h00;
                m_strobe[d] = 1'b0;
            end
        end else if (s_reload) begin
            m_ldq.delete();
            m_run = 1'b0;
            for (int d = 0; d < 2; d++) m_strobe[d] = 1'b0;
        end else if (m_run) begin
            for (int d = 0; d < 2; d++) begin
                m_strobe[d] = 1'b0;
                if (s_write) begin
                    if (d == 0 && s_addr == 8'hFF) begin
                        m_io_out[d] = s_din;
                        m_strobe[d] = 1'b1;
                    end else begin
                        m_ram[d][s_addr]   = s_din;
                        m_known[d][s_addr] = 1'b1;
                    end
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) m_strobe[d] = 1'b0;
            if (s_ld_valid) begin
                m_ldq.push_back(s_ld_data);
                n = m_ldq.size();
                if (n >= 3) begin
                    for (int d = 0; d < 2; d++) begin
                        m_ram[d][8'(int'(m_ldq[0]) + n - 3)]   = s_ld_data;
                        m_known[d][8'(int'(m_ldq[0]) + n - 3)] = 1'b1;
                    end
                end
                if (n >= 2) begin
                    len = (m_ldq[1] == 8'h00) ? 256 : int'(m_ldq[1]);
                    if (n == len + 2) m_run = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        push_expect();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        s_write = 1'b0; s_ld_valid = 1'b0; s_reload = 1'b0;
        cycle();
    endtask

    task automatic send(logic [7:0] b, bit gap);
        if (gap) begin
            s_ld_valid = 1'b0;
            s_ld_data  = 8'($urandom);
            cycle();
        end
        s_ld_valid = 1'b1;
        s_ld_data  = b;
        cycle();
        s_ld_valid = 1'b0;
    endtask

    task automatic cpu_write(logic [7:0] a, logic [7:0] v);
        s_addr = a; s_din = v; s_write = 1'b1;
        cycle();
        s_write = 1'b0;
    endtask

    task automatic rd(logic [7:0] a);
        s_addr = a;
        cycle();
    endtask

    task automatic do_reload();
        s_reload = 1'b1;
        cycle();
        s_reload = 1'b0;
    endtask

    initial begin
        int w;
        m_run = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_io_out[d] = 8'h00;
            m_strobe[d] = 1'b0;
            for (int a = 0; a < 256; a++) m_known[d][a] = 1'b0;
        end
        reset = 1'b1;
        s_addr = 8'h00; s_din = 8'h00; s_ld_data = 8'h00; s_io_in = 8'h00;
        s_write = 1'b0; s_ld_valid = 1'b0; s_reload = 1'b0;
        @(posedge clk); #1;

        // reset-state check
        check_now("rst cpu_reset dut0", 8'(if0.cpu_reset), 8'h01);
        check_now("rst ld_ready dut0",  8'(if0.ld_ready),  8'h01);
        check_now("rst loaded dut0",    8'(if0.loaded),    8'h00);
        check_now("rst io_out dut0",    if0.io_out,        8'h00);
        check_now("rst io_strobe dut0", 8'(if0.io_strobe), 8'h00);
        check_now("rst cpu_reset dut1", 8'(if1.cpu_reset), 8'h01);
        check_now("rst ld_ready dut1",  8'(if1.ld_ready),  8'h01);
        check_now("rst loaded dut1",    8'(if1.loaded),    8'h00);

        cycle();
        chk_en = 1'b1;
        reset = 1'b0;
        idle();

        // basic load with ld_valid held
        send(8'h00, 0); send(8'h03, 0);
        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0);

        // bounded wait for loaded
        w = 0;
        while (!if0.loaded && w < 4) begin
            idle();
            w++;
        end
        if (!if0.loaded) begin
            n_bad++;
            $display("FAIL timeout waiting for loaded t=%0t", $time);
        end
        n_cmp++;

        idle();
        rd(8'h00); rd(8'h01); rd(8'h02);

        // wrapping load with a stalling loader
        do_reload();
        cnt_clr = 1'b1; idle(); cnt_clr = 1'b0;
        send(8'hFE, 1); send(8'h04, 1);
        send(8'h11, 1); send(8'h22, 1); send(8'h33, 1); send(8'h44, 1);
        idle();
        push(0, K_XFER, 8'd6);
        rd(8'hFE); rd(8'hFF); rd(8'h00); rd(8'h01);

        // CPU RAM and I/O writes
        cpu_write(8'h10, 8'h5A);
        rd(8'h10);
        s_io_in = 8'h77;
        cpu_write(8'hFF, 8'h3C);
        idle(); idle();
        rd(8'hFF);

        // reload mid-DATA beats the pending byte
        do_reload();
        send(8'h30, 0); send(8'h05, 0); send(8'h01, 0); send(8'h02, 0);
        s_reload = 1'b1; s_ld_valid = 1'b1; s_ld_data = 8'h55;
        cycle();
        s_reload = 1'b0; s_ld_valid = 1'b0;
        idle();
        send(8'h40, 0); send(8'h02, 0); send(8'h66, 0); send(8'h77, 0);
        idle();
        rd(8'h30); rd(8'h31); rd(8'h40); rd(8'h41);

        // CPU write ignored while loading the header
        cpu_write(8'h20, 8'hAB);
        do_reload();
        send(8'h50, 0);
        cpu_write(8'h20, 8'h99);
        send(8'h01, 0); send(8'h88, 0);
        idle();
        rd(8'h20); rd(8'h50);

        // synchronous reset in RUN keeps RAM
        cpu_write(8'hFF, 8'hC5);
        idle();
        reset = 1'b1;
        s_addr = 8'h21; s_din = 8'h12; s_write = 1'b1;
        cycle();
        reset = 1'b0; s_write = 1'b0;
        idle();
        rd(8'h10); rd(8'h20); rd(8'h41);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_addr     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            s_din      = 8'($urandom);
            s_io_in    = 8'($urandom);
            s_write    = ($urandom_range(0, 2) == 0);
            s_ld_valid = ($urandom_range(0, 1) == 0);
            s_ld_data  = (m_ldq.size() == 1) ? 8'($urandom_range(1, 6)) : 8'($urandom);
            s_reload   = ($urandom_range(0, 59) == 0);
            reset      = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the 8-bit CPU memory interface: 256x8 RAM answering `mem_addr` / `mem_in` / `write` from the processor with a combinational read path.
- Contains a byte-stream program loader FSM that holds the CPU in reset while filling RAM, then releases it.
- Maps one address to an I/O port: output latch plus input read-back.
- Sits between the processor and the board-level loader/peripheral logic.

Parameters:
- IO_ADDR, 8'hFF, CPU address decoded as the I/O port instead of RAM.
- IO_EN, 1, 1 enables the I/O decode; 0 makes IO_ADDR ordinary RAM.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- mem_addr  in  8  CPU address.
- mem_in  in  8  CPU write data.
- write  in  1  CPU write strobe, sampled at rising clk.
- mem_out  out  8  read data for mem_addr, combinational.
- cpu_reset  out  1  reset to the processor, high while not in RUN.
- ld_data  in  8  loader byte.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  responder accepts loader byte.
- reload  in  1  one-cycle request to re-enter load mode.
- io_in  in  8  value returned on CPU read of IO_ADDR.
- io_out  out  8  last value the CPU wrote to IO_ADDR.
- io_strobe  out  1  one-cycle pulse after each CPU write to IO_ADDR.
- loaded  out  1  high in RUN.

Behaviour:
- Reset (clk, reset: synchronous, active-high) values:
  - FSM goes to HDR_ADDR.
  - cpu_reset=1, ld_ready=1, loaded=0, io_out=8'h00, io_strobe=0.
  - Internal load pointer and count = 0.
  - RAM contents are not cleared: undefined at power-up, preserved across reset.
- Read path:
  - mem_out = io_in when IO_EN and mem_addr==IO_ADDR; otherwise mem_out = ram[mem_addr].
  - Zero latency, purely combinational from mem_addr. The CPU samples the data in the same cycle it presents the address.
- CPU write:
  - Acts only in RUN with write=1.
  - If mem_addr==IO_ADDR (IO_EN=1): io_out<=mem_in, RAM unchanged, and io_strobe=1 in the following cycle only.
  - Otherwise ram[mem_addr]<=mem_in at the edge; a read of that address shows the new data from the next cycle.
  - write is ignored outside RUN.
- Loader handshake:
  - A byte transfers on a rising edge with ld_valid && ld_ready.
  - ld_ready = 1 in HDR_ADDR, HDR_LEN and DATA; 0 in RUN.
  - ld_valid may stall arbitrarily; no byte is lost or duplicated.
- FSM:
  - HDR_ADDR: on transfer, ptr<=ld_data, then HDR_LEN.
  - HDR_LEN: on transfer, cnt<=ld_data, then DATA. cnt=0 means 256 bytes.
  - DATA: on transfer, ram[ptr]<=ld_data, ptr<=ptr+1 (8-bit wrap 8'hFF->8'h00), cnt<=cnt-1. On the transfer that completes the count, go to RUN.
  - Loader writes to IO_ADDR go to RAM, not to io_out (loader has no I/O decode).
  - RUN: cpu_reset=0, loaded=1, ld_ready=0. Stays until reload or reset.
- cpu_reset and loaded are registered from state. The first cycle in RUN has cpu_reset=0, so the CPU comes out of reset one cycle after the final data byte edge.
- reload=1 in any state: next state is HDR_ADDR, cpu_reset=1 next cycle.
  - Takes priority over a simultaneous loader transfer; that byte is not consumed, and ld_ready is forced 0 that cycle.
  - Takes priority over a simultaneous CPU write in RUN; the write is dropped.
- reset mid-load: the load is abandoned, bytes already written stay in RAM, FSM restarts at HDR_ADDR.
- io_out and io_strobe are not affected by reload.

Test Plan:
- Reset, stream 00,03,A1,B2,C3 with ld_valid held -> ram[0..2]=A1,B2,C3; loaded=1 and cpu_reset=0 the cycle after the C3 edge; ld_ready=0 afterwards.
- Header FE,04, data 11,22,33,44 with ld_valid toggling every other cycle -> ram[FE]=11, ram[FF]=22, ram[00]=33, ram[01]=44 (pointer wraps); exactly 6 transfers.
- RUN, CPU writes 5A to 0x10 -> mem_out at mem_addr=10 reads 5A from the next cycle; write to 0xFF with 3C -> io_out=3C, io_strobe high exactly one cycle, ram[FF] unchanged.
- RUN, io_in=77, mem_addr=FF -> mem_out=77 same cycle. With IO_EN=0, write 3C to FF -> ram[FF]=3C and no io_strobe.
- Mid-DATA (2 of 5 bytes loaded), reload asserted with ld_valid=1 -> that byte not consumed, FSM back to HDR_ADDR, cpu_reset stays 1, the next byte is taken as the start address.
- write=1 asserted during HDR_LEN with mem_addr=20, mem_in=99 -> ram[20] unchanged; synchronous reset in RUN -> cpu_reset=1, loaded=0, io_out=00, RAM retains its data.
